// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types for the uart subsystem (word-length encoding).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        WORD_LEN_5 = 2'd0,
        WORD_LEN_6 = 2'd1,
        WORD_LEN_7 = 2'd2,
        WORD_LEN_8 = 2'd3
    } word_len_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module : uart_tx_if
// Brief  : Byte handshake between a byte source and the UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done
    );

endinterface : uart_tx_if

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : Oversampled UART transmitter: start, 5-8 data bits LSB first,
//          optional parity, 1/1.5/2 stop bits, forced-break override.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      div_clk_en,
    uart_tx_if.slave       bus,
    output logic           tx,
    input  word_len_e      cfg_word_len,
    input  wire logic      cfg_stop_bits,
    input  wire logic      cfg_parity_en,
    input  wire logic      cfg_even_parity,
    input  wire logic      cfg_force_parity,
    input  wire logic      cfg_break
);

    // Longest bit is a 2-stop period, so the counter must reach 2*OVERSAMPLE-1.
    localparam int CNT_W = $clog2(2 * OVERSAMPLE);

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] C_STOP1     = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] C_STOP15    = CNT_W'((OVERSAMPLE * 3) / 2 - 1);
    localparam logic [CNT_W-1:0] C_STOP2     = CNT_W'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    word_len_e        word_len_q,  word_len_d;
    logic             par_en_q,    par_en_d;
    logic             par_bit_q,   par_bit_d;
    logic [CNT_W-1:0] stop_last_q, stop_last_d;
    logic             tx_q,        tx_d;
    logic             done_q,      done_d;

    logic             w_accept;
    logic             w_bit_last;
    logic [CNT_W-1:0] w_cnt_last;
    logic [2:0]       w_data_last;
    logic [7:0]       w_data_mask;
    logic             w_par_calc;
    logic             w_line;

    assign w_accept    = (state_q == S_IDLE) && bus.tx_valid;
    assign w_data_last = 3'd4 + {1'b0, word_len_q};
    assign w_data_mask = 8'hFF >> (2'd3 - cfg_word_len);

    // Parity is fixed at accept time from the live configuration.
    always_comb begin
        w_par_calc = 1'b0;
        if (cfg_force_parity) begin
            w_par_calc = ~cfg_even_parity;
        end else begin
            w_par_calc = (^(bus.tx_data & w_data_mask)) ^ ~cfg_even_parity;
        end
    end

    always_comb begin
        w_cnt_last = C_BIT_LAST;
        if (state_q == S_STOP) begin
            w_cnt_last = stop_last_q;
        end
    end

    assign w_bit_last = div_clk_en && (cnt_q == w_cnt_last);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        word_len_d  = word_len_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop_last_d = stop_last_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (div_clk_en) begin
            cnt_d = w_bit_last ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d    = S_START;
                    bit_idx_d  = 3'd0;
                    shift_d    = bus.tx_data;
                    word_len_d = cfg_word_len;
                    par_en_d   = cfg_parity_en;
                    par_bit_d  = w_par_calc;
                    if (!cfg_stop_bits) begin
                        stop_last_d = C_STOP1;
                    end else if (cfg_word_len == WORD_LEN_5) begin
                        stop_last_d = C_STOP15;
                    end else begin
                        stop_last_d = C_STOP2;
                    end
                end
            end
            S_START: begin
                if (w_bit_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    if (bit_idx_q == w_data_last) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_last) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is derived from where the FSM will be after this edge.
    always_comb begin
        w_line = 1'b1;
        case (state_d)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = shift_d[0];
            S_PARITY: w_line = par_bit_d;
            default:  w_line = 1'b1;
        endcase
        tx_d = w_line & ~cfg_break;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            word_len_q  <= WORD_LEN_8;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_last_q <= C_STOP1;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            word_len_q  <= word_len_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop_last_q <= stop_last_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign tx           = tx_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_ready = (state_q == S_IDLE);

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module : tb_uart_tx
// Brief  : Self-checking bench for uart_tx against a per-pulse line model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;
    import uart_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      div_clk_en = 1'b0;
    logic      tx;
    word_len_e cfg_word_len = WORD_LEN_8;
    logic      cfg_stop_bits = 1'b0;
    logic      cfg_parity_en = 1'b0;
    logic      cfg_even_parity = 1'b0;
    logic      cfg_force_parity = 1'b0;
    logic      cfg_break = 1'b0;

    uart_tx_if bus ();

    uart_tx #(.OVERSAMPLE(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .div_clk_en       (div_clk_en),
        .bus              (bus),
        .tx               (tx),
        .cfg_word_len     (cfg_word_len),
        .cfg_stop_bits    (cfg_stop_bits),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_even_parity  (cfg_even_parity),
        .cfg_force_parity (cfg_force_parity),
        .cfg_break        (cfg_break)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: parity makes total ones even (even=1) or odd (even=0).
    function automatic int model_par(input logic [7:0] d, input int wl,
                                     input logic even, input logic frc);
        int ones = 0;
        for (int i = 0; i < wl; i++) ones += int'(d[i]);
        if (frc) return even ? 0 : 1;
        return even ? (ones % 2) : 1 - (ones % 2);
    endfunction

    function automatic int model_stop(input int wl, input logic stp);
        if (!stp) return 16;
        return (wl == 5) ? 24 : 32;
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge of the
    // tx_done cycle, so a caller may immediately queue another byte.
    task automatic run_frame(input logic [7:0] d, input int wl, input logic stp,
                             input logic pen, input logic even, input logic frc,
                             input int period, input int exp_par, input int exp_stop,
                             input int brk_at, input int brk_len, output int cycles);
        logic q[$];
        int   pulses;
        int   c;
        logic brk_prev;
        logic exp_tx;
        bus.tx_data      = d;
        cfg_word_len     = word_len_e'(2'(wl - 5));
        cfg_stop_bits    = stp;
        cfg_parity_en    = pen;
        cfg_even_parity  = even;
        cfg_force_parity = frc;
        cfg_break        = 1'b0;
        div_clk_en       = 1'b0;
        bus.tx_valid     = 1'b1;
        @(posedge clk);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(1'b0);
        for (int b = 0; b < wl; b++)
            for (int i = 0; i < 16; i++) q.push_back(d[b]);
        if (exp_par >= 0)
            for (int i = 0; i < 16; i++) q.push_back(exp_par[0]);
        for (int i = 0; i < exp_stop; i++) q.push_back(1'b1);
        pulses   = 0;
        c        = 0;
        brk_prev = 1'b0;
        while (1) begin
            @(negedge clk);
            exp_tx = (pulses < q.size()) ? q[pulses] : 1'b1;
            if (brk_prev) exp_tx = 1'b0;
            chk("tx_line", int'(tx), int'(exp_tx));
            chk("tx_done", int'(bus.tx_done), int'(pulses == q.size()));
            chk("tx_ready", int'(bus.tx_ready), int'(pulses == q.size()));
            if (pulses == q.size()) break;
            if (c > 20000) begin
                chk("frame_timeout", c, -1);
                break;
            end
            div_clk_en = ((c % period) == period - 1);
            if (div_clk_en) pulses++;
            cfg_break = (c >= brk_at) && (c < brk_at + brk_len);
            brk_prev  = cfg_break;
            // Busy-time traffic on the handshake and config must be ignored.
            bus.tx_valid     = 1'($urandom);
            bus.tx_data      = 8'($urandom);
            cfg_word_len     = word_len_e'(2'($urandom));
            cfg_stop_bits    = 1'($urandom);
            cfg_parity_en    = 1'($urandom);
            cfg_even_parity  = 1'($urandom);
            cfg_force_parity = 1'($urandom);
            c++;
        end
        cycles       = c;
        div_clk_en   = 1'b0;
        cfg_break    = 1'b0;
        bus.tx_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, int'(bus.tx_done), 0);
        chk({tag, "_ready"}, int'(bus.tx_ready), 1);
        chk({tag, "_tx"}, int'(tx), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         wl;
        logic       stp;
        logic       pen;
        logic       even;
        logic       frc;
        int         period;
        int         exp_par;
        int         exp_stop;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[11];
    int   cyc;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        vecs[0]  = '{8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 16, 160};
        vecs[1]  = '{8'h03, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1,  0, 16, 160};
        vecs[2]  = '{8'h03, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1, 16, 160};
        vecs[3]  = '{8'h03, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1,  0, 16, 160};
        vecs[4]  = '{8'h03, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1,  1, 16, 160};
        vecs[5]  = '{8'h83, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1,  0, 16, 160};
        vecs[6]  = '{8'h83, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1, 16, 160};
        vecs[7]  = '{8'hC4, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, 32, 176};
        vecs[8]  = '{8'h15, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, 24, 120};
        vecs[9]  = '{8'h2A, 6, 1'b0, 1'b1, 1'b1, 1'b0, 2,  1, 16, 288};
        vecs[10] = '{8'hF0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 4,  1, 32, 768};

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle_check("reset_idle");

        // Table-driven frames.
        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].wl, vecs[i].stp, vecs[i].pen,
                      vecs[i].even, vecs[i].frc, vecs[i].period,
                      vecs[i].exp_par, vecs[i].exp_stop, 1 << 30, 0, cyc);
            chk("frame_cycles", cyc, vecs[i].exp_cycles);
            idle_check("post_frame");
        end

        // Back-to-back: second byte offered in the tx_done cycle.
        run_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 16, 1 << 30, 0, cyc);
        chk("b2b_first_cycles", cyc, 160);
        run_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 16, 1 << 30, 0, cyc);
        chk("b2b_second_cycles", cyc, 160);
        idle_check("post_b2b");

        // Break during data bit 3 (pulses 64..79 -> cycles 256..319 at /4).
        run_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4, -1, 16, 264, 20, cyc);
        chk("break_cycles", cyc, 640);
        idle_check("post_break");

        // Randomized frames against the reference model.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int         wl, per, par, stopn;
            logic       stp, pen, even, frc;
            d     = 8'($urandom);
            wl    = $urandom_range(5, 8);
            stp   = 1'($urandom);
            pen   = 1'($urandom);
            even  = 1'($urandom);
            frc   = 1'($urandom);
            per   = $urandom_range(1, 4);
            par   = pen ? model_par(d, wl, even, frc) : -1;
            stopn = model_stop(wl, stp);
            run_frame(d, wl, stp, pen, even, frc, per, par, stopn, 1 << 30, 0, cyc);
            chk("rand_cycles", cyc,
                per * (16 * (1 + wl + (pen ? 1 : 0)) + stopn));
            if ($urandom_range(0, 1) == 0) idle_check("rand_idle");
        end

        // Reset asserted mid-frame: line returns high without a clock edge.
        @(negedge clk);
        bus.tx_data  = 8'h00;
        cfg_word_len = WORD_LEN_8;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        div_clk_en   = 1'b1;
        repeat (5) @(negedge clk);
        chk("midframe_tx_low", int'(tx), 0);
        chk("midframe_busy", int'(bus.tx_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", int'(tx), 1);
        chk("async_rst_ready", int'(bus.tx_ready), 1);
        chk("async_rst_done", int'(bus.tx_done), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        div_clk_en = 1'b0;
        idle_check("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx

`default_nettype wire
